// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Brief    : Registered multi-cycle ALU with a valid/ready request handshake.
//             Single-cycle ops return one cycle after accept; MUL runs as an
//             iterative shift-add over WIDTH cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 8,
    parameter int IMM_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] alu_in,
    input  logic [WIDTH-1:0] accum,
    input  logic             pc_in,
    output logic             res_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_err
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [3:0] c_op_nop = 4'b0000;
    localparam logic [3:0] c_op_ldo = 4'b0001;
    localparam logic [3:0] c_op_lda = 4'b0010;
    localparam logic [3:0] c_op_sto = 4'b0011;
    localparam logic [3:0] c_op_pre = 4'b0100;
    localparam logic [3:0] c_op_add = 4'b0101;
    localparam logic [3:0] c_op_ldm = 4'b0110;
    localparam logic [3:0] c_op_adn = 4'b0111;
    localparam logic [3:0] c_op_inc = 4'b1000;
    localparam logic [3:0] c_op_dec = 4'b1001;
    localparam logic [3:0] c_op_jmp = 4'b1010;
    localparam logic [3:0] c_op_sub = 4'b1011;
    localparam logic [3:0] c_op_mul = 4'b1100;
    localparam logic [3:0] c_op_and = 4'b1101;
    localparam logic [3:0] c_op_or  = 4'b1110;
    localparam logic [3:0] c_op_hlt = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_ready;
    logic                   w_accept;

    logic [WIDTH-1:0]       r_out;
    logic                   r_res_valid;
    logic                   r_z;
    logic                   r_c;
    logic                   r_n;
    logic                   r_err;

    logic [WIDTH-1:0]       r_mcand;
    logic [2*WIDTH-1:0]     r_prod;     // {partial high half, remaining multiplier bits}
    logic [c_cnt_w-1:0]     r_cnt;
    logic [WIDTH:0]         w_mul_sum;
    logic [2*WIDTH-1:0]     w_prod_nxt;

    logic [WIDTH-1:0]       w_imm;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH-1:0]       w_res;
    logic                   w_c;
    logic                   w_err;

    assign w_accept  = op_valid & w_ready;
    assign op_ready  = w_ready;
    assign res_valid = r_res_valid;
    assign alu_out   = r_out;
    assign flag_z    = r_z;
    assign flag_c    = r_c;
    assign flag_n    = r_n;
    assign flag_err  = r_err;

    // One shift-add step: add multiplicand when the current multiplier LSB is set, then shift right.
    assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and ready: busy only while multiply steps are running; DONE accepts like IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b1;
        case (r_state)
            S_MUL: begin
                w_ready = 1'b0;
                if (r_cnt == c_cnt_one) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_IDLE, S_DONE: begin
                if (w_accept && (op == c_op_mul)) begin
                    w_state_nxt = S_MUL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Single-cycle result and carry/error for the opcode presented at accept.
    always_comb begin
        w_imm = '0;
        for (int i = 0; i < IMM_W; i++) begin
            w_imm[i] = alu_in[i];
        end
        w_sum = '0;
        w_res = accum;
        w_c   = 1'b0;
        w_err = 1'b0;
        case (op)
            c_op_nop: w_res = pc_in ? alu_in : accum;
            c_op_ldo, c_op_lda, c_op_pre, c_op_jmp: w_res = alu_in;
            c_op_sto, c_op_ldm, c_op_hlt, c_op_mul: w_res = accum;
            c_op_add: begin
                w_sum = {1'b0, accum} + {1'b0, alu_in};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
            end
            c_op_adn: begin
                w_sum = {1'b0, accum} + {1'b0, w_imm};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
            end
            c_op_inc: begin
                w_sum = {1'b0, accum} + (WIDTH + 1)'(1);
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
            end
            c_op_dec: w_res = (accum == '0) ? '0 : accum - WIDTH'(1);
            c_op_sub: begin
                w_sum = {1'b0, accum} - {1'b0, alu_in};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
            end
            c_op_and: w_res = accum & alu_in;
            c_op_or:  w_res = accum | alu_in;
            default: begin
                w_res = accum;
                w_err = 1'b1;
            end
        endcase
    end

    // Result/flag registers and multiplier datapath; flags move only together with res_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_res_valid <= 1'b0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_n         <= 1'b0;
            r_err       <= 1'b0;
            r_mcand     <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
        end else begin
            r_res_valid <= 1'b0;
            if (r_state == S_MUL) begin
                r_prod <= w_prod_nxt;
                r_cnt  <= r_cnt - c_cnt_one;
                if (r_cnt == c_cnt_one) begin
                    r_out       <= w_prod_nxt[WIDTH-1:0];
                    r_c         <= |w_prod_nxt[2*WIDTH-1:WIDTH];
                    r_z         <= (w_prod_nxt[WIDTH-1:0] == '0);
                    r_n         <= w_prod_nxt[WIDTH-1];
                    r_err       <= 1'b0;
                    r_res_valid <= 1'b1;
                end
            end else if (w_accept) begin
                if (op == c_op_mul) begin
                    r_mcand <= accum;
                    r_prod  <= {{WIDTH{1'b0}}, alu_in};
                    r_cnt   <= c_cnt_init;
                end else begin
                    r_out       <= w_res;
                    r_c         <= w_c;
                    r_z         <= (w_res == '0);
                    r_n         <= w_res[WIDTH-1];
                    r_err       <= w_err;
                    r_res_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
